// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite register master.
// Holds the master FSM state type, the AXI response codes and the default
// protection value driven on AWPROT/ARPROT.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_timeout_cnt.sv
// Transaction timeout counter.
// Saturating up-counter with synchronous clear and count enable; expired is
// high while the count sits at TIMEOUT_CYCLES-1.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clr     : synchronous clear (wins over en)
//   en      : count enable
//   expired : count has reached TIMEOUT_CYCLES-1
module axi_lite_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/axi_lite_reg_master.sv
// AXI-lite register master.
// Accepts single-beat read/write commands on a valid/ready command port,
// runs one AXI-lite transaction per command and returns data/response on a
// valid/ready response port. An unresponsive slave is abandoned after
// TIMEOUT_CYCLES with rsp_timeout=1 and rsp_resp=SLVERR.
//   s_axi_aclk, s_axi_areset   : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake
//   cmd_wr, cmd_addr           : direction (1=write) and address
//   cmd_wdata, cmd_wstrb       : write data and byte strobes
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata, rsp_resp        : read data (0 for writes/timeout), BRESP/RRESP
//   rsp_timeout                : transaction aborted by timeout
//   busy                       : FSM not idle
//   M_AXI_LITE_*               : AXI-lite master channels AW, W, B, AR, R
module axi_lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] M_AXI_LITE_awaddr,
    output logic [2:0]            M_AXI_LITE_awprot,
    output logic                  M_AXI_LITE_awvalid,
    input  logic                  M_AXI_LITE_awready,
    output logic [31:0]           M_AXI_LITE_wdata,
    output logic [3:0]            M_AXI_LITE_wstrb,
    output logic                  M_AXI_LITE_wvalid,
    input  logic                  M_AXI_LITE_wready,
    input  logic [1:0]            M_AXI_LITE_bresp,
    input  logic                  M_AXI_LITE_bvalid,
    output logic                  M_AXI_LITE_bready,
    output logic [ADDR_WIDTH-1:0] M_AXI_LITE_araddr,
    output logic [2:0]            M_AXI_LITE_arprot,
    output logic                  M_AXI_LITE_arvalid,
    input  logic                  M_AXI_LITE_arready,
    input  logic [31:0]           M_AXI_LITE_rdata,
    input  logic [1:0]            M_AXI_LITE_rresp,
    input  logic                  M_AXI_LITE_rvalid,
    output logic                  M_AXI_LITE_rready
);

    state_t                state, state_d;
    logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic                  rsp_valid_d, rsp_timeout_d;
    logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic [31:0]           wdata_d, rsp_rdata_d;
    logic [3:0]            wstrb_d;
    logic [1:0]            rsp_resp_d;
    logic                  cnt_clr, cnt_en, expired, abort;
    logic                  aw_done, w_done;

    axi_lite_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (s_axi_aclk),
        .rst     (s_axi_areset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    assign cmd_ready         = (state == ST_IDLE) && !s_axi_areset;
    assign busy              = (state != ST_IDLE);
    assign M_AXI_LITE_awprot = PROT_DEFAULT;
    assign M_AXI_LITE_arprot = PROT_DEFAULT;

    // Both valids rise together on entry to WR_REQ, so a valid that is
    // already low means that channel's handshake has happened.
    assign aw_done = !M_AXI_LITE_awvalid || M_AXI_LITE_awready;
    assign w_done  = !M_AXI_LITE_wvalid  || M_AXI_LITE_wready;

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d       = state;
        awaddr_d      = M_AXI_LITE_awaddr;
        awvalid_d     = M_AXI_LITE_awvalid;
        wdata_d       = M_AXI_LITE_wdata;
        wstrb_d       = M_AXI_LITE_wstrb;
        wvalid_d      = M_AXI_LITE_wvalid;
        bready_d      = M_AXI_LITE_bready;
        araddr_d      = M_AXI_LITE_araddr;
        arvalid_d     = M_AXI_LITE_arvalid;
        rready_d      = M_AXI_LITE_rready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        abort         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_clr = 1'b1;
                    if (cmd_wr) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end

            ST_WR_REQ: begin
                cnt_en = 1'b1;
                if (aw_done && w_done) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_WR_RESP;
                end else begin
                    if (M_AXI_LITE_awvalid && M_AXI_LITE_awready) awvalid_d = 1'b0;
                    if (M_AXI_LITE_wvalid && M_AXI_LITE_wready)   wvalid_d  = 1'b0;
                    abort = expired;
                end
            end

            ST_WR_RESP: begin
                cnt_en = 1'b1;
                if (M_AXI_LITE_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = M_AXI_LITE_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RSP;
                end else begin
                    abort = expired;
                end
            end

            ST_RD_REQ: begin
                cnt_en = 1'b1;
                if (M_AXI_LITE_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_RESP;
                end else begin
                    abort = expired;
                end
            end

            ST_RD_RESP: begin
                cnt_en = 1'b1;
                if (M_AXI_LITE_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = M_AXI_LITE_rdata;
                    rsp_resp_d    = M_AXI_LITE_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RSP;
                end else begin
                    abort = expired;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Timeout abort is shared by all four bus states; it is only raised
        // when no completing handshake was seen this cycle.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            state_d       = ST_RSP;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state              <= ST_IDLE;
            M_AXI_LITE_awaddr  <= '0;
            M_AXI_LITE_awvalid <= 1'b0;
            M_AXI_LITE_wdata   <= '0;
            M_AXI_LITE_wstrb   <= '0;
            M_AXI_LITE_wvalid  <= 1'b0;
            M_AXI_LITE_bready  <= 1'b0;
            M_AXI_LITE_araddr  <= '0;
            M_AXI_LITE_arvalid <= 1'b0;
            M_AXI_LITE_rready  <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= '0;
            rsp_timeout        <= 1'b0;
        end else begin
            state              <= state_d;
            M_AXI_LITE_awaddr  <= awaddr_d;
            M_AXI_LITE_awvalid <= awvalid_d;
            M_AXI_LITE_wdata   <= wdata_d;
            M_AXI_LITE_wstrb   <= wstrb_d;
            M_AXI_LITE_wvalid  <= wvalid_d;
            M_AXI_LITE_bready  <= bready_d;
            M_AXI_LITE_araddr  <= araddr_d;
            M_AXI_LITE_arvalid <= arvalid_d;
            M_AXI_LITE_rready  <= rready_d;
            rsp_valid          <= rsp_valid_d;
            rsp_rdata          <= rsp_rdata_d;
            rsp_resp           <= rsp_resp_d;
            rsp_timeout        <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Testbench for axi_lite_reg_master: a behavioural test-register slave with
// delay/stall/response knobs, a register-file reference model, directed
// scenarios and a randomized command loop.
module tb_axi_lite_reg_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_reg_master #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .s_axi_aclk         (clk),
        .s_axi_areset       (areset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_wr             (cmd_wr),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .cmd_wstrb          (cmd_wstrb),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_resp           (rsp_resp),
        .rsp_timeout        (rsp_timeout),
        .busy               (busy),
        .M_AXI_LITE_awaddr  (awaddr),
        .M_AXI_LITE_awprot  (awprot),
        .M_AXI_LITE_awvalid (awvalid),
        .M_AXI_LITE_awready (awready),
        .M_AXI_LITE_wdata   (wdata),
        .M_AXI_LITE_wstrb   (wstrb),
        .M_AXI_LITE_wvalid  (wvalid),
        .M_AXI_LITE_wready  (wready),
        .M_AXI_LITE_bresp   (bresp),
        .M_AXI_LITE_bvalid  (bvalid),
        .M_AXI_LITE_bready  (bready),
        .M_AXI_LITE_araddr  (araddr),
        .M_AXI_LITE_arprot  (arprot),
        .M_AXI_LITE_arvalid (arvalid),
        .M_AXI_LITE_arready (arready),
        .M_AXI_LITE_rdata   (rdata),
        .M_AXI_LITE_rresp   (rresp),
        .M_AXI_LITE_rvalid  (rvalid),
        .M_AXI_LITE_rready  (rready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave knobs ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic        aw_stall = 1'b0, r_stall = 1'b0, rdata_ovr = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // ---------------- test-register slave ----------------
    // 0x0, 0x4, 0xC plain registers; reading 0x8 returns reg0 + reg1.
    logic [31:0] s_mem [4];
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_hs_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [15:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign awready = awvalid && !aw_stall && !aw_got && (aw_cnt >= aw_delay);
    assign wready  = wvalid && !w_got && (w_cnt >= w_delay);
    assign arready = arvalid && !rvalid && (ar_cnt >= ar_delay);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs) && !bvalid;
    assign wr_idx  = aw_got ? aw_addr_q[3:2] : awaddr[3:2];
    assign wr_data = w_got ? w_data_q : wdata;
    assign wr_strb = w_got ? w_strb_q : wstrb;

    always @(posedge clk) begin
        if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
        if (areset) begin
            for (int i = 0; i < 4; i++) s_mem[i] <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (wr_fire) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) s_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
                if (w_hs)  begin w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; end
                if (bvalid && bready) bvalid <= 1'b0;
            end
            if (ar_hs && !r_stall) begin
                rvalid <= 1'b1;
                rresp  <= rresp_cfg;
                if (rdata_ovr)                rdata <= 32'hDEADBEEF;
                else if (araddr[3:2] == 2'd2) rdata <= s_mem[0] + s_mem[1];
                else                          rdata <= s_mem[araddr[3:2]];
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // ---------------- channel protocol monitor ----------------
    logic prev_aw_hs, prev_aw_wait, prev_w_hs, prev_w_wait;
    int   aw_viol = 0, w_viol = 0, split_cnt = 0;

    always @(negedge clk) begin
        if (areset || !busy) begin
            prev_aw_hs <= 1'b0; prev_aw_wait <= 1'b0;
            prev_w_hs  <= 1'b0; prev_w_wait  <= 1'b0;
        end else begin
            if (prev_aw_hs && awvalid) aw_viol <= aw_viol + 1;
            else if (prev_aw_wait && !awvalid && !(rsp_valid && rsp_timeout)) aw_viol <= aw_viol + 1;
            if (prev_w_hs && wvalid) w_viol <= w_viol + 1;
            else if (prev_w_wait && !wvalid && !(rsp_valid && rsp_timeout)) w_viol <= w_viol + 1;
            if (!awvalid && wvalid) split_cnt <= split_cnt + 1;
            prev_aw_hs   <= awvalid && awready;
            prev_aw_wait <= awvalid && !awready;
            prev_w_hs    <= wvalid && wready;
            prev_w_wait  <= wvalid && !wready;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [4];

    task automatic ref_clear();
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    endtask

    task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[3:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        if (a[3:2] == 2'd2) return ref_mem[0] + ref_mem[1];
        return ref_mem[a[3:2]];
    endfunction

    // ---------------- command driver ----------------
    int          last_acc = 0, last_hs = 0;
    logic [31:0] last_rd;
    logic [4:0]  chan_at_rsp;

    // Called and returns on a negedge. Response is taken after 'hold' extra
    // cycles with rsp_ready low, checking payload stability meanwhile.
    task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, input string tag,
                          output logic [31:0] rd, output logic [1:0] rs,
                          output logic to, output int lat);
        int   guard;
        logic stable;
        rd = '0; rs = '0; to = 1'b0; lat = -1;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            check_eq({tag, "_accept"}, cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 200) begin @(negedge clk); guard++; end
        if (!rsp_valid) begin
            check_eq({tag, "_rsp_arrive"}, rsp_valid, 1);
            return;
        end
        lat = cyc + 1 - last_acc;
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        last_rd = rd;
        chan_at_rsp = {awvalid, wvalid, bready, arvalid, rready};
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_rdata !== rd || rsp_resp !== rs || rsp_timeout !== to)
                stable = 1'b0;
        end
        if (hold > 0) check_eq({tag, "_hold_stable"}, stable, 1);
        rsp_ready = 1'b1;
        last_hs = cyc + 1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s, input int hold,
                           input int exp_lat);
        logic [31:0] erd, rd;
        logic [1:0]  ers, rs;
        logic        to;
        int          lat;
        if (wr) begin
            ref_write(a, d, s);
            erd = '0;
            ers = bresp_cfg;
        end else begin
            erd = rdata_ovr ? 32'hDEADBEEF : ref_read(a);
            ers = rresp_cfg;
        end
        do_cmd(wr, a, d, s, hold, tag, rd, rs, to, lat);
        check_eq({tag, "_rdata"}, rd, erd);
        check_eq({tag, "_resp"}, rs, ers);
        check_eq({tag, "_timeout"}, to, 0);
        if (exp_lat >= 0) check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        ref_clear();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        int          lat, b0, s0, saved_hs, guard, late_rsp;

        areset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        ref_clear();
        repeat (3) @(negedge clk);

        // reset state
        check_eq("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                                rsp_timeout, busy, cmd_ready}, 0);
        check_eq("reset_payload", {rsp_rdata, rsp_resp, awaddr, araddr}, 0);
        areset = 1'b0;
        @(negedge clk);
        check_eq("cmd_ready_idle", cmd_ready, 1);
        check_eq("prot", {awprot, arprot}, 0);

        // register-sum sequence, zero-wait slave
        run_txn("wr0", 1'b1, 16'h0000, 32'h12345678, 4'hF, 0, 3);
        run_txn("wr4", 1'b1, 16'h0004, 32'h00000001, 4'hF, 0, 3);
        run_txn("rd8", 1'b0, 16'h0008, 32'h0, 4'h0, 0, 3);
        check_eq("rd8_value", last_rd, 32'h12345679);

        // W channel ready late relative to AW
        w_delay = 5;
        b0 = b_hs_cnt; s0 = split_cnt;
        run_txn("wdly", 1'b1, 16'h000C, 32'hCAFE0001, 4'hF, 0, 8);
        check_eq("wdly_b_handshakes", 64'(b_hs_cnt - b0), 1);
        check_eq("wdly_aw_dropped_first", 64'(split_cnt - s0 > 0), 1);
        check_eq("wdly_aw_viol", 64'(aw_viol), 0);
        check_eq("wdly_w_viol", 64'(w_viol), 0);
        w_delay = 0;

        // timeout with awready tied low
        aw_stall = 1'b1;
        b0 = b_hs_cnt;
        do_cmd(1'b1, 16'h0004, 32'hAAAA5555, 4'hF, 0, "tmo", rd, rs, to, lat);
        check_eq("tmo_latency", 64'(lat), 64'(TO + 1));
        check_eq("tmo_flag", to, 1);
        check_eq("tmo_resp", rs, 2'b10);
        check_eq("tmo_rdata", rd, 0);
        check_eq("tmo_channels_low", chan_at_rsp, 0);
        check_eq("tmo_no_bresp", 64'(b_hs_cnt - b0), 0);
        aw_stall = 1'b0;
        pulse_reset();

        // error response passthrough
        rdata_ovr = 1'b1; rresp_cfg = 2'b11;
        run_txn("rderr", 1'b0, 16'h0000, 32'h0, 4'h0, 0, 3);
        check_eq("rderr_value", last_rd, 32'hDEADBEEF);
        rdata_ovr = 1'b0; rresp_cfg = 2'b00;

        // response back-pressure, then back-to-back command
        run_txn("hold", 1'b1, 16'h0004, 32'h0BADF00D, 4'h3, 10, 3);
        saved_hs = last_hs;
        run_txn("b2b", 1'b0, 16'h0004, 32'h0, 4'h0, 0, 3);
        check_eq("b2b_accept_cycle", 64'(last_acc), 64'(saved_hs + 1));

        // reset while waiting for R
        r_stall = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0004;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!rready && guard < 50) begin @(negedge clk); guard++; end
        check_eq("rst_reached_rd_resp", rready, 1);
        areset = 1'b1;
        @(negedge clk);
        check_eq("rst_outputs_low", {arvalid, rready, rsp_valid, busy, cmd_ready}, 0);
        areset = 1'b0;
        r_stall = 1'b0;
        ref_clear();
        late_rsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) late_rsp++;
        end
        check_eq("rst_no_response", 64'(late_rsp), 0);
        run_txn("rd_after_rst", 1'b0, 16'h0004, 32'h0, 4'h0, 0, 3);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic [1:0]  idx;
            logic [15:0] a;
            int          el;
            aw_delay  = $urandom_range(0, 3);
            w_delay   = $urandom_range(0, 3);
            ar_delay  = $urandom_range(0, 3);
            bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            wr  = 1'($urandom_range(0, 1));
            idx = 2'($urandom_range(0, 3));
            if (wr && idx == 2'd2) idx = 2'd3;
            a = {12'h000, idx, 2'b00};
            el = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) : 3 + ar_delay;
            run_txn($sformatf("rnd%0d", i), wr, a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2), el);
        end

        check_eq("aw_protocol", 64'(aw_viol), 0);
        check_eq("w_protocol", 64'(w_viol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
